// File: rtl/hazard_ctrl.sv
// Decode hazard/flush control: load scoreboard, mul/div occupancy, stretched trap flush; stall/clear act in the same cycle.
// No backpressure of its own; hang is a sticky watchdog flag. HAZARD_PERF_EN adds stall/flush event counters.
`timescale 1ns/1ps
module hazard_ctrl #(
   parameter int FLUSH_CYCLES  = 2,
   parameter int STALL_TIMEOUT = 1023,
   parameter int CNT_W         = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic        ld_issue,
   input  logic [4:0]  ld_rd,
   input  logic        wb_ld_valid,
   input  logic [4:0]  wb_ld_rd,
   input  logic        md_start,
   input  logic        md_done,
   input  logic        bj_en,
   input  logic        trap_en,
   output logic        stall,
   output logic        clear,
   output logic        md_kill,
   output logic        hang,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(STALL_TIMEOUT);

   typedef enum logic [1:0] {RUN, MD_BUSY, FLUSH} state_t;

   state_t          state;
   logic [FC_W-1:0] fcnt;
   logic [31:0]     pend;
   logic [31:0]     pend_nxt;
   logic            load_hz;
   logic            stall_c;
   logic            clear_c;
   logic [CNT_W-1:0] wd_cnt;
   logic [CNT_W-1:0] wd_nxt;

   // Set is applied after clear so a same-cycle issue/writeback of one index stays pending.
   always_comb begin
      pend_nxt = pend;
      if (wb_ld_valid) pend_nxt[wb_ld_rd] = 1'b0;
      if (ld_issue)    pend_nxt[ld_rd]    = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend <= '0;
      else        pend <= pend_nxt;
   end

   assign load_hz = id_valid && ((id_use_rs1 && pend[id_rs1]) || (id_use_rs2 && pend[id_rs2]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         fcnt  <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (trap_en) begin
                  state <= FLUSH;
                  fcnt  <= FC_LOAD;
               end else if (md_start) begin
                  state <= MD_BUSY;
               end
            end
            MD_BUSY: begin
               if (trap_en) begin
                  state <= FLUSH;
                  fcnt  <= FC_LOAD;
               end else if (md_done) begin
                  state <= RUN;
               end
            end
            FLUSH: begin
               if (trap_en)           fcnt  <= FC_LOAD;
               else if (fcnt == '0)   state <= RUN;
               else                   fcnt  <= fcnt - FC_W'(1);
            end
            default: state <= RUN;
         endcase
      end
   end

   // Redirects outrank every stall source, so stall and clear are mutually exclusive.
   always_comb begin
      stall_c = 1'b0;
      clear_c = 1'b0;
      if (trap_en || state == FLUSH)        clear_c = 1'b1;
      else if (bj_en)                       clear_c = 1'b1;
      else if (state == MD_BUSY && !md_done) stall_c = 1'b1;
      else if (load_hz)                     stall_c = 1'b1;
   end

   assign stall   = rst_n && stall_c;
   assign clear   = rst_n && clear_c;
   assign md_kill = rst_n && (state == MD_BUSY) && trap_en;

   always_comb begin
      wd_nxt = '0;
      if (stall) wd_nxt = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         hang   <= 1'b0;
      end else begin
         wd_cnt <= wd_nxt;
         if (wd_nxt == WD_MAX) hang <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (stall)            perf_stall_q <= perf_stall_q + 32'd1;
         if (trap_en || bj_en) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`else
   assign perf_stall_cnt = 32'h0;
   assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: per-cycle expectations go into a queue as stimulus is applied and are popped at the sampling edge.
`timescale 1ns/1ps
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid, id_use_rs1, id_use_rs2, ld_issue, wb_ld_valid;
   logic [4:0]  id_rs1, id_rs2, ld_rd, wb_ld_rd;
   logic        md_start, md_done, bj_en, trap_en;
   logic        stall, clear, md_kill, hang;
   logic [31:0] perf_stall_cnt, perf_flush_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] exp_q[$];

   hazard_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(15), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ld_issue(ld_issue), .ld_rd(ld_rd),
      .wb_ld_valid(wb_ld_valid), .wb_ld_rd(wb_ld_rd),
      .md_start(md_start), .md_done(md_done),
      .bj_en(bj_en), .trap_en(trap_en),
      .stall(stall), .clear(clear), .md_kill(md_kill), .hang(hang),
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       id_v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       ld;
      logic [4:0] ld_rd;
      logic       wb;
      logic [4:0] wb_rd;
      logic       ms;
      logic       md;
      logic       bj;
      logic       tr;
      logic       e_stall;
      logic       e_clear;
      logic       e_kill;
   } stim_t;

   function automatic stim_t st(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                                input logic u1, input logic u2,
                                input logic ld, input logic [4:0] lrd,
                                input logic wb, input logic [4:0] wrd,
                                input logic ms, input logic md, input logic bj, input logic tr,
                                input logic es, input logic ec, input logic ek);
      stim_t s;
      s.id_v = v;  s.rs1 = r1;  s.rs2 = r2;  s.u1 = u1;  s.u2 = u2;
      s.ld = ld;   s.ld_rd = lrd; s.wb = wb; s.wb_rd = wrd;
      s.ms = ms;   s.md = md;   s.bj = bj;  s.tr = tr;
      s.e_stall = es; s.e_clear = ec; s.e_kill = ek;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      id_valid = s.id_v;  id_rs1 = s.rs1;  id_rs2 = s.rs2;
      id_use_rs1 = s.u1;  id_use_rs2 = s.u2;
      ld_issue = s.ld;    ld_rd = s.ld_rd;
      wb_ld_valid = s.wb; wb_ld_rd = s.wb_rd;
      md_start = s.ms;    md_done = s.md;
      bj_en = s.bj;       trap_en = s.tr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      apply(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [3:0] e;
      // Every input active while in reset: nothing may reach the outputs or the scoreboard.
      apply(st(1,1,1,1,1, 1,1, 0,0, 1,0,1,1, 0,0,0));
      exp_q.push_back(4'b0000);
      #2;
      e = exp_q.pop_front();
      n_tests++;
      if ({stall, clear, md_kill, hang} !== e) begin
         n_fail++;
         $display("FAIL reset_comb: stall,clear,md_kill,hang=%b expected %b", {stall, clear, md_kill, hang}, e);
      end
      n_tests++;
      if (perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_perf: stall_cnt=%0d flush_cnt=%0d expected 0/0", perf_stall_cnt, perf_flush_cnt);
      end
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(4'b0000);
      e = exp_q.pop_front();
      n_tests++;
      if ({stall, clear, md_kill, hang} !== e) begin
         n_fail++;
         $display("FAIL reset_held: stall,clear,md_kill,hang=%b expected %b", {stall, clear, md_kill, hang}, e);
      end
      do_reset();
      apply(st(1,1,0,1,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
      exp_q.push_back(4'b0000);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if ({stall, clear, md_kill, hang} !== e) begin
         n_fail++;
         $display("FAIL reset_release: stall,clear,md_kill,hang=%b expected %b", {stall, clear, md_kill, hang}, e);
      end
      tick();
   endtask

   task automatic test_load_use();
      stim_t t[$];
      logic [3:0] e;
      do_reset();
      t.push_back(st(1,5,0,1,0, 1,5, 0,0, 0,0,0,0, 0,0,0));
      t.push_back(st(1,5,0,1,0, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(1,5,0,1,0, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(1,5,0,1,0, 0,0, 1,5, 0,0,0,0, 1,0,0));
      t.push_back(st(1,5,0,1,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
      t.push_back(st(1,0,0,1,0, 1,0, 0,0, 0,0,0,0, 0,0,0));
      t.push_back(st(1,0,0,1,1, 0,0, 0,0, 0,0,0,0, 0,0,0));
      t.push_back(st(1,9,3,0,1, 1,9, 0,0, 0,0,0,0, 0,0,0));
      t.push_back(st(1,9,3,0,1, 0,0, 0,0, 0,0,0,0, 0,0,0));
      t.push_back(st(1,0,9,0,1, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(0,0,9,0,1, 0,0, 0,0, 0,0,0,0, 0,0,0));
      t.push_back(st(1,0,9,0,1, 0,0, 1,9, 0,0,0,0, 1,0,0));
      t.push_back(st(1,0,9,0,1, 0,0, 0,0, 0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]);
         exp_q.push_back({t[i].e_stall, t[i].e_clear, t[i].e_kill, 1'b0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if ({stall, clear, md_kill, hang} !== e) begin
            n_fail++;
            $display("FAIL load_use[%0d]: stall,clear,md_kill,hang=%b expected %b", i, {stall, clear, md_kill, hang}, e);
         end
         tick();
      end
   endtask

   task automatic test_collision();
      stim_t t[$];
      logic [3:0] e;
      do_reset();
      t.push_back(st(0,0,0,0,0, 1,7, 1,7, 0,0,0,0, 0,0,0));
      t.push_back(st(1,0,7,0,1, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(1,0,7,0,1, 0,0, 1,7, 0,0,0,0, 1,0,0));
      t.push_back(st(1,0,7,0,1, 0,0, 0,0, 0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]);
         exp_q.push_back({t[i].e_stall, t[i].e_clear, t[i].e_kill, 1'b0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if ({stall, clear, md_kill, hang} !== e) begin
            n_fail++;
            $display("FAIL collision[%0d]: stall,clear,md_kill,hang=%b expected %b", i, {stall, clear, md_kill, hang}, e);
         end
         tick();
      end
   endtask

   task automatic test_md_div();
      stim_t t[$];
      logic [3:0] e;
      do_reset();
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 1,0,0,0, 0,0,0));
      for (int k = 0; k < 8; k++) t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,1,0,0, 0,0,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
      // Trap mid-op: kill pulse on the trap cycle, clear for four cycles, md_start/md_done ignored in FLUSH.
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 1,0,0,0, 0,0,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,1, 0,1,1));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,1,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 1,0,0,0, 0,1,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,1,0,0, 0,1,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
      // Branch while busy clears but keeps the op; md_start while busy is ignored.
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 1,0,0,0, 0,0,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,1,0, 0,1,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 1,0,0,0, 1,0,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,1,0,0, 0,0,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]);
         exp_q.push_back({t[i].e_stall, t[i].e_clear, t[i].e_kill, 1'b0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if ({stall, clear, md_kill, hang} !== e) begin
            n_fail++;
            $display("FAIL md_div[%0d]: stall,clear,md_kill,hang=%b expected %b", i, {stall, clear, md_kill, hang}, e);
         end
         tick();
      end
   endtask

   task automatic test_flush_priority();
      stim_t t[$];
      logic [3:0] e;
      do_reset();
      t.push_back(st(0,4,0,1,0, 1,4, 0,0, 0,0,0,0, 0,0,0));
      t.push_back(st(1,4,0,1,0, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(1,4,0,1,0, 0,0, 0,0, 0,0,1,0, 0,1,0));
      t.push_back(st(1,4,0,1,0, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(1,4,0,1,0, 0,0, 0,0, 0,0,0,1, 0,1,0));
      t.push_back(st(1,4,0,1,0, 0,0, 0,0, 0,0,0,0, 0,1,0));
      t.push_back(st(1,4,0,1,0, 0,0, 0,0, 0,0,0,1, 0,1,0));
      for (int k = 0; k < 3; k++) t.push_back(st(1,4,0,1,0, 0,0, 0,0, 0,0,0,0, 0,1,0));
      // The load survives the trap, so the hazard is back once the flush ends.
      t.push_back(st(1,4,0,1,0, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(1,4,0,1,0, 0,0, 1,4, 0,0,0,0, 1,0,0));
      t.push_back(st(1,4,0,1,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]);
         exp_q.push_back({t[i].e_stall, t[i].e_clear, t[i].e_kill, 1'b0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if ({stall, clear, md_kill, hang} !== e) begin
            n_fail++;
            $display("FAIL flush_prio[%0d]: stall,clear,md_kill,hang=%b expected %b", i, {stall, clear, md_kill, hang}, e);
         end
         tick();
      end
   endtask

   task automatic test_watchdog();
      logic [3:0] e;
      logic       es;
      logic       hang_m;
      int         run;
      do_reset();
      hang_m = 1'b0;
      run = 0;
      for (int j = 0; j < 23; j++) begin
         es = (j >= 1 && j <= 20);
         apply(st(es,2,0,1,0, (j == 0),2, 0,0, 0,0,0,0, 0,0,0));
         exp_q.push_back({es, 1'b0, 1'b0, hang_m});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if ({stall, clear, md_kill, hang} !== e) begin
            n_fail++;
            $display("FAIL watchdog[%0d]: stall,clear,md_kill,hang=%b expected %b", j, {stall, clear, md_kill, hang}, e);
         end
         tick();
         run = es ? run + 1 : 0;
         if (run >= 15) hang_m = 1'b1;
      end
      // Enter MD_BUSY, trap in it, then drop rst_n mid-cycle with the trap still driven.
      apply(st(0,0,0,0,0, 0,0, 0,0, 1,0,0,0, 0,0,0));
      tick();
      apply(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,1, 0,0,0));
      exp_q.push_back(4'b0111);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if ({stall, clear, md_kill, hang} !== e) begin
         n_fail++;
         $display("FAIL busy_trap: stall,clear,md_kill,hang=%b expected %b", {stall, clear, md_kill, hang}, e);
      end
      #2;
      rst_n = 1'b0;
      exp_q.push_back(4'b0000);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({stall, clear, md_kill, hang} !== e) begin
         n_fail++;
         $display("FAIL async_reset: stall,clear,md_kill,hang=%b expected %b", {stall, clear, md_kill, hang}, e);
      end
      apply(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_perf();
      stim_t t[$];
      logic [3:0]  e;
      logic [31:0] exp_ps;
      logic [31:0] exp_pf;
      do_reset();
      t.push_back(st(0,3,0,1,0, 1,3, 0,0, 0,0,0,0, 0,0,0));
      for (int k = 0; k < 6; k++) t.push_back(st(1,3,0,1,0, 0,0, 0,0, 0,0,0,0, 1,0,0));
      t.push_back(st(0,3,0,1,0, 0,0, 1,3, 0,0,0,0, 0,0,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,1,0, 0,1,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,1,0, 0,1,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,1, 0,1,0));
      for (int k = 0; k < 3; k++) t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,1,0));
      t.push_back(st(0,0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
      foreach (t[i]) begin
         apply(t[i]);
         exp_q.push_back({t[i].e_stall, t[i].e_clear, t[i].e_kill, 1'b0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if ({stall, clear, md_kill, hang} !== e) begin
            n_fail++;
            $display("FAIL perf_seq[%0d]: stall,clear,md_kill,hang=%b expected %b", i, {stall, clear, md_kill, hang}, e);
         end
         tick();
      end
`ifdef HAZARD_PERF_EN
      exp_ps = 32'd6;
      exp_pf = 32'd3;
`else
      exp_ps = 32'd0;
      exp_pf = 32'd0;
`endif
      n_tests++;
      if (perf_stall_cnt !== exp_ps) begin
         n_fail++;
         $display("FAIL perf_stall_cnt: got %0d expected %0d", perf_stall_cnt, exp_ps);
      end
      n_tests++;
      if (perf_flush_cnt !== exp_pf) begin
         n_fail++;
         $display("FAIL perf_flush_cnt: got %0d expected %0d", perf_flush_cnt, exp_pf);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_collision();
      test_md_div();
      test_flush_priority();
      test_watchdog();
      test_perf();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: bench still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and flush controller for the in-order core.
- Drives the decode stage's stall and clear inputs.
- Tracks in-flight load destinations in a register scoreboard, sequences multi-cycle mul/div occupancy, and stretches trap flushes over a programmable number of cycles.
- Sits beside decode; consumes ID-stage operand indices plus EX/WB status.

Parameters:
- FLUSH_CYCLES, 2: cycles clear stays asserted after a trap (min 1).
- STALL_TIMEOUT, 1023: consecutive stall cycles before the hang flag asserts.
- CNT_W, 10: width of the stall watchdog counter; must hold STALL_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs1  in  5  ID source register 1 index
- id_rs2  in  5  ID source register 2 index
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ld_issue  in  1  load leaving EX this cycle
- ld_rd  in  5  destination of the issuing load
- wb_ld_valid  in  1  load data written back this cycle
- wb_ld_rd  in  5  destination of the writing-back load
- md_start  in  1  mul/div unit accepted an op
- md_done  in  1  mul/div result available
- bj_en  in  1  branch/jump redirect resolved
- trap_en  in  1  trap/exception redirect
- stall  out  1  hold IF/ID (feeds decode stall)
- clear  out  1  kill ID/EX contents (feeds decode clear)
- md_kill  out  1  abort the in-progress mul/div op
- hang  out  1  sticky stall-watchdog flag
- perf_stall_cnt  out  32  stall-cycle counter (optional feature)
- perf_flush_cnt  out  32  flush-event counter (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, pend=32'h0, flush counter 0, watchdog 0.
  - hang=0, md_kill=0, perf counters 0.
  - stall=0 and clear=0 while in reset.
- Scoreboard pend[31:0], registered:
  - ld_issue && ld_rd!=0 sets pend[ld_rd].
  - wb_ld_valid clears pend[wb_ld_rd].
  - Same index set and cleared in one cycle: set wins.
  - pend[0] is always 0.
  - Traps do not clear pend; outstanding loads still write back.
- load_hz (combinational) = id_valid && ((id_use_rs1 && pend[id_rs1]) || (id_use_rs2 && pend[id_rs2])).
- FSM states RUN, MD_BUSY, FLUSH:
  - RUN: trap_en -> FLUSH with counter loaded to FLUSH_CYCLES-1; else md_start -> MD_BUSY; else stay.
  - MD_BUSY: trap_en -> FLUSH and md_kill=1 for exactly that cycle; md_done -> RUN; else stay. md_start is ignored in this state.
  - FLUSH: counter decrements each cycle; at 0 -> RUN. trap_en in FLUSH reloads the counter. md_start is ignored.
- Outputs (combinational from state and inputs, same-cycle effect), priority high to low:
  - trap_en, or state==FLUSH: clear=1, stall=0.
  - bj_en: clear=1 for that cycle only, stall=0, state unchanged. A bj_en in MD_BUSY does not kill the mul/div op.
  - state==MD_BUSY && !md_done: stall=1.
  - load_hz: stall=1.
  - otherwise: stall=0, clear=0.
- Stall and clear are never both 1.
- Watchdog:
  - Increments (saturating) while stall=1; resets to 0 when stall=0.
  - hang is set when the count reaches STALL_TIMEOUT.
  - hang is cleared only by reset.
- Latency: a load issued in cycle N makes a dependent ID instruction stall from cycle N+1 until the cycle after wb_ld_valid for that rd.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments (wrapping) every cycle stall=1.
  - perf_flush_cnt increments once per trap_en or bj_en cycle; +1 when both are asserted together.
- Undefined: both ports are tied to 32'h0 and no counter flops are instantiated.

Test Plan:
- Load-use: ld_issue rd=5, next cycle ID reads rs1=5 -> stall=1 each cycle until the cycle after wb_ld_valid rd=5, then stall=0. Same sequence with rd=0 -> no stall.
- Set/clear collision: ld_issue rd=7 and wb_ld_valid rd=7 in the same cycle -> pend[7]=1; dependent ID stalls.
- Mul/div: md_start, md_done 8 cycles later -> stall=1 for 8 cycles, 0 on the md_done cycle. Trap mid-op -> md_kill pulses 1 cycle, clear=1 for FLUSH_CYCLES+1 cycles total.
- Flush priority: bj_en while load_hz=1 -> clear=1, stall=0. trap_en with FLUSH_CYCLES=3 -> clear high 4 cycles; a second trap in cycle 2 extends clear to cycle 5.
- Watchdog: STALL_TIMEOUT=15, hold the hazard for 20 cycles -> hang rises on stall cycle 15 and stays 1 after the hazard drops; async rst_n mid-MD_BUSY -> all outputs 0 immediately.
- HAZARD_PERF_EN defined: 6 stall cycles, 2 bj_en, 1 trap -> perf_stall_cnt=6, perf_flush_cnt=3. Undefined: both read 0.
